// File: rtl/mux_scan_if.sv
// Bus bundle for mux_scan_ctrl: scan request and range, abort, mux select and
// sample input, captured vector and status pulses.
// MUX_SCAN_PARITY_EN adds the parity output.
interface mux_scan_if #(
  parameter int N = 16,
  parameter int M = $clog2(N)
);
  logic         start;
  logic [M-1:0] first_ch;
  logic [M-1:0] last_ch;
  logic         abort;
  logic [M-1:0] select;
  logic         mux_out;
  logic [N-1:0] data;
  logic         busy;
  logic         done;
  logic         err;
`ifdef MUX_SCAN_PARITY_EN
  logic         parity;

  modport master (
    output start, first_ch, last_ch, abort, mux_out,
    input  select, data, busy, done, err, parity
  );
  modport slave (
    input  start, first_ch, last_ch, abort, mux_out,
    output select, data, busy, done, err, parity
  );
`else
  modport master (
    output start, first_ch, last_ch, abort, mux_out,
    input  select, data, busy, done, err
  );
  modport slave (
    input  start, first_ch, last_ch, abort, mux_out,
    output select, data, busy, done, err
  );
`endif
endinterface

// File: rtl/mux_scan_ctrl.sv
// Analog-mux scan controller: steps the select through [first_ch, last_ch].
// For each channel it holds the select for SETTLE cycles and then samples
// mux_out into data[channel].
// Optional macro MUX_SCAN_PARITY_EN adds a parity output over the scanned bits.
// The interface instance must be built with the same N and M as this module.
module mux_scan_ctrl #(
  parameter int N      = 16,
  parameter int M      = $clog2(N),
  parameter int SETTLE = 2
) (
  input logic     clk,
  input logic     rst_n,
  mux_scan_if.slave bus
);
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(SETTLE - 1);
  localparam logic [M:0]    N_EXT    = (M+1)'(N);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [M-1:0]  select_q, select_d;
  logic [M-1:0]  last_q, last_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  data_q, data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          range_ok;
`ifdef MUX_SCAN_PARITY_EN
  logic          parity_q, parity_d;
`endif

  // The range is valid when it is ordered and it ends on an existing channel.
  always_comb range_ok = (bus.first_ch <= bus.last_ch) && ({1'b0, bus.last_ch} < N_EXT);

  // Next-state logic. Abort takes priority over the capture in SAMPLE.
  always_comb begin
    state_d  = state_q;
    select_d = select_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
`ifdef MUX_SCAN_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (range_ok) begin
            state_d  = S_SETTLE;
            select_d = bus.first_ch;
            last_d   = bus.last_ch;
            data_d   = '0;
            cnt_d    = CNT_LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (bus.abort)          state_d = S_IDLE;
        else if (cnt_q == '0)   state_d = S_SAMPLE;
        else                    cnt_d   = cnt_q - CW'(1);
      end
      S_SAMPLE: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else begin
          data_d[select_q] = bus.mux_out;
          if (select_q == last_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
`ifdef MUX_SCAN_PARITY_EN
            // Bits outside the range were cleared at acceptance, so a full
            // reduction equals the XOR over first_ch..last_ch.
            parity_d = ^data_d;
`endif
          end else begin
            state_d  = S_SETTLE;
            select_d = select_q + M'(1);
            cnt_d    = CNT_LOAD;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_SAMPLE);
  end

  // State and output registers. Reset is asynchronous, so a scan in progress
  // is discarded at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      select_q <= '0;
      last_q   <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      select_q <= select_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
`ifdef MUX_SCAN_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign bus.select = select_q;
  assign bus.data   = data_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
`ifdef MUX_SCAN_PARITY_EN
  assign bus.parity = parity_q;
`endif
endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl (N=16, SETTLE=2).
// The reference model is timeline based: it counts edges since acceptance
// and derives select, busy, done and data from that count.
// Compiling with MUX_SCAN_PARITY_EN also checks parity.
module tb_mux_scan_ctrl;
  localparam int N = 16;
  localparam int M = 4;
  localparam int SETTLE = 2;
  localparam int P = SETTLE + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [N-1:0] pattern = '0;
  int n_chk = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  mux_scan_if #(.N(N), .M(M)) bus();

  mux_scan_ctrl #(.N(N), .M(M), .SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  // The mux is modelled as a fixed per-channel bit pattern.
  assign bus.mux_out = pattern[bus.select];

  // Reference model: a scan of K channels spans K*P edges after acceptance.
  // Channel j is sampled on edge (j+1)*P, and done is high after edge K*P.
  bit           m_active, m_in_done, m_busy, m_done, m_err, m_par;
  int           m_t, m_first, m_last;
  logic [M-1:0] m_sel;
  logic [N-1:0] m_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 0; m_in_done = 0; m_busy = 0; m_done = 0; m_err = 0; m_par = 0;
      m_t = 0; m_sel = '0; m_data = '0;
    end else begin
      m_done = 0; m_err = 0;
      if (m_active) begin
        if (bus.abort) begin
          m_active = 0; m_busy = 0;
        end else begin
          m_t++;
          if (m_t % P == 0) begin
            int ch;
            ch = m_first + m_t / P - 1;
            m_data[ch] = pattern[ch];
            if (m_t == (m_last - m_first + 1) * P) begin
              m_active = 0; m_busy = 0; m_done = 1; m_in_done = 1; m_par = ^m_data;
            end else begin
              m_sel = M'(ch + 1);
            end
          end
        end
      end else if (m_in_done) begin
        m_in_done = 0;
      end else if (bus.start) begin
        if (int'(bus.first_ch) <= int'(bus.last_ch) && int'(bus.last_ch) < N) begin
          m_active = 1; m_busy = 1; m_t = 0;
          m_first = int'(bus.first_ch); m_last = int'(bus.last_ch);
          m_sel = bus.first_ch; m_data = '0;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare the DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("mdl_select", 64'(bus.select), 64'(m_sel));
      check("mdl_data",   64'(bus.data),   64'(m_data));
      check("mdl_busy",   64'(bus.busy),   64'(m_busy));
      check("mdl_done",   64'(bus.done),   64'(m_done));
      check("mdl_err",    64'(bus.err),    64'(m_err));
`ifdef MUX_SCAN_PARITY_EN
      check("mdl_parity", 64'(bus.parity), 64'(m_par));
`endif
    end
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  // Start a scan and count edges from acceptance until done is seen.
  // With mid_start set, a conflicting request is raised mid-scan.
  task automatic do_scan(input int f, input int l, input bit mid_start, output int edges);
    bus.first_ch = M'(f); bus.last_ch = M'(l); bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("sel_at_accept", 64'(bus.select), 64'(f));
    edges = 0;
    while (!bus.done && edges < 2000) begin
      if (mid_start && edges == 5) begin
        bus.first_ch = 4'd1; bus.last_ch = 4'd2; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0; bus.first_ch = M'(f); bus.last_ch = M'(l);
      end
      tick;
      edges++;
    end
    bus.start = 1'b0;
  endtask

  initial begin
    int e;
    int dones;
    bus.start = 0; bus.abort = 0; bus.first_ch = '0; bus.last_ch = '0;
    #12 rst_n = 1'b1;
    tick;
    cmp_en = 1'b1;
    check("rst_select", 64'(bus.select), 64'd0);
    check("rst_data",   64'(bus.data),   64'd0);
    check("rst_busy",   64'(bus.busy),   64'd0);
    check("rst_done",   64'(bus.done),   64'd0);
    check("rst_err",    64'(bus.err),    64'd0);

    // Channels 0..3, only channel 2 high, plus an ignored start mid-scan.
    pattern = 16'h0004;
    do_scan(0, 3, 1'b1, e);
    check("s1_done_edge", 64'(e), 64'd12);
    check("s1_data", 64'(bus.data), 64'h0004);
    check("s1_sel_last", 64'(bus.select), 64'd3);
    tick;
    check("s1_done_pulse", 64'(bus.done), 64'd0);

    // Single channel 13.
    pattern = '1;
    do_scan(13, 13, 1'b0, e);
    check("s2_done_edge", 64'(e), 64'd3);
    check("s2_data", 64'(bus.data), 64'h2000);
    tick; tick;

    // Abort in IDLE does nothing.
    bus.abort = 1'b1; tick; bus.abort = 1'b0; tick;
    check("idle_abort_data", 64'(bus.data), 64'h2000);

    // Reversed range flags err for one cycle only.
    bus.first_ch = 4'd5; bus.last_ch = 4'd2; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    check("s3_err", 64'(bus.err), 64'd1);
    check("s3_busy", 64'(bus.busy), 64'd0);
    tick;
    check("s3_err_clear", 64'(bus.err), 64'd0);
    check("s3_data", 64'(bus.data), 64'h2000);
    check("s3_sel", 64'(bus.select), 64'd13);

    // Full scan with an abort after seven samples.
    bus.first_ch = 4'd0; bus.last_ch = 4'd15; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    e = 0;
    while (bus.data != 16'h007F && e < 200) begin tick; e++; end
    check("s4_reach7", 64'(e < 200), 64'd1);
    bus.abort = 1'b1; tick; bus.abort = 1'b0;
    check("s4_busy", 64'(bus.busy), 64'd0);
    dones = 0;
    for (int i = 0; i < 60; i++) begin tick; if (bus.done) dones++; end
    check("s4_no_done", 64'(dones), 64'd0);
    check("s4_data", 64'(bus.data), 64'h007F);

    // Asynchronous reset during the settle of channel 4.
    bus.first_ch = 4'd0; bus.last_ch = 4'd15; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    e = 0;
    while (bus.select != 4'd4 && e < 200) begin tick; e++; end
    check("s5_reach4", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("s5_rst_sel", 64'(bus.select), 64'd0);
    check("s5_rst_data", 64'(bus.data), 64'd0);
    check("s5_rst_busy", 64'(bus.busy), 64'd0);
    #10 rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 60; i++) begin tick; if (bus.done) dones++; end
    check("s5_no_done", 64'(dones), 64'd0);

    // Full scan with channels 1, 5 and 9 high.
    pattern = 16'h0222;
    do_scan(0, 15, 1'b0, e);
    check("s6_done_edge", 64'(e), 64'd48);
    check("s6_data", 64'(bus.data), 64'h0222);
`ifdef MUX_SCAN_PARITY_EN
    check("s6_parity", 64'(bus.parity), 64'd1);
`endif
    tick; tick;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/mux_scan_ctrl.md
MUX_SCAN_CTRL -- requirements
Module: mux_scan_ctrl

Interface
REQ-001 SHALL have parameter N, default 16: number of mux channels scanned (2..64).
REQ-002 SHALL have parameter M, default $clog2(N): select width.
REQ-003 SHALL have parameter SETTLE, default 2: cycles the select is held before sampling (>=1).
REQ-004 SHALL have port clk  input  1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-006 SHALL have port start  input  1: scan request, sampled in IDLE only.
REQ-007 SHALL have port first_ch  input  M: first channel of the scan range.
REQ-008 SHALL have port last_ch  input  M: last channel of the scan range, inclusive.
REQ-009 SHALL have port abort  input  1: terminates an active scan.
REQ-010 SHALL have port select  output  M: drives the downstream N:1 mux select.
REQ-011 SHALL have port mux_out  input  1: the mux output being sampled.
REQ-012 SHALL have port data  output  N: captured vector, bit i holds the channel i sample.
REQ-013 SHALL have port busy  output  1: high in SETTLE and SAMPLE.
REQ-014 SHALL have port done  output  1: one-cycle completion pulse.
REQ-015 SHALL have port err  output  1: one-cycle invalid-range pulse.

Function
REQ-016 SHALL implement FSM states IDLE, SETTLE, SAMPLE, DONE; all outputs registered.
REQ-017 In IDLE, start=1 with first_ch<=last_ch and last_ch<N SHALL latch the range, set select=first_ch, clear data to 0, load settle counter with SETTLE-1, and enter SETTLE.
REQ-018 In IDLE, start=1 with first_ch>last_ch or last_ch>=N SHALL pulse err for one cycle, stay in IDLE, and leave select and data unchanged.
REQ-019 SETTLE SHALL last exactly SETTLE cycles (counter decrements each cycle), then enter SAMPLE.
REQ-020 SAMPLE SHALL last one cycle: data[select] <= mux_out; other bits unchanged.
REQ-021 From SAMPLE, if select==latched last_ch, SHALL enter DONE; otherwise select <= select+1, reload counter, enter SETTLE.
REQ-022 DONE SHALL assert done for exactly one cycle, then return to IDLE; select holds last_ch.
REQ-023 Scan of K=last_ch-first_ch+1 channels SHALL assert done starting K*(SETTLE+1) rising edges after the edge that accepted start.
REQ-024 start while busy or in DONE SHALL be ignored; first_ch/last_ch changes during a scan SHALL have no effect.
REQ-025 abort=1 in SETTLE or SAMPLE SHALL return to IDLE on the next edge with no done, no sample taken that edge, and data retaining bits captured so far; abort takes priority over SAMPLE capture.
REQ-026 abort in IDLE or DONE SHALL be ignored.
REQ-027 data SHALL be stable outside SAMPLE; select SHALL change only on SAMPLE->SETTLE or scan acceptance.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, select=0, data=0, busy=0, done=0, err=0, counter=0, regardless of the clock.
REQ-029 Reset mid-scan SHALL discard the scan; no done pulse after release.

Configuration
REQ-030 With macro MUX_SCAN_PARITY_EN defined, SHALL add output parity (1 bit, reset 0), updated in DONE to XOR of data bits first_ch..last_ch and held until next DONE or reset.
REQ-031 Without MUX_SCAN_PARITY_EN, port parity and its logic SHALL not exist; all other behaviour identical.

Verification
REQ-032 N=16, SETTLE=2, first=0, last=3, mux_out=1 only when select==2 -> data=16'h0004, done at edge 12 after start.
REQ-033 first=13, last=13, mux_out=1 -> select=13 after acceptance, data=16'h2000, done at edge 3.
REQ-034 first=5, last=2 start -> err one cycle, busy never high, data unchanged.
REQ-035 first=0, last=15, mux_out=1, abort after 7 SAMPLE cycles -> IDLE, no done, data=16'h007F.
REQ-036 rst_n low during SETTLE of channel 4 -> all outputs 0 immediately; no done after release.
REQ-037 With MUX_SCAN_PARITY_EN, first=0, last=15, mux_out=1 on channels 1,5,9 -> data=16'h0222, parity=1.
